// File: rtl/riscv_pkg.sv
// Shared controller definitions: FSM state type, opcodes and datapath select codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } statetype;

  // Major opcodes handled by the multicycle core
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALUOp encodings consumed by the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU operand B selects
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// Main multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes and selects. Outputs are decoded from the
// state register; only IRWrite/PCUpdate in FETCH are qualified by MemReady.
module mainfsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       IllegalOp
);

  statetype state_q;
  statetype state_d;

  // State register with synchronous reset into FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unreachable encodings recover to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      JAL:      state_d = ALUWB;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted so an
  // abandoned store or writeback cannot leak a strobe in the reset cycle
  always_comb begin
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    ALUOp     = ALUOP_ADD;
    IllegalOp = 1'b0;
    if (reset) begin
      IllegalOp = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = MemReady;
          PCUpdate  = MemReady;
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: IllegalOp = 1'b0;
            default:                                  IllegalOp = 1'b1;
          endcase
        end
        MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        MEMREAD: begin
          AdrSrc = 1'b1;
        end
        MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTER: begin
          ALUSrcA = SRCA_RD1;
          ALUOp   = ALUOP_FUNCT;
        end
        EXECUTEI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        ALUWB: begin
          RegWrite = 1'b1;
        end
        JAL: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCUpdate = 1'b1;
        end
        BEQ: begin
          ALUSrcA = SRCA_RD1;
          ALUOp   = ALUOP_SUB;
          Branch  = 1'b1;
        end
        default: begin
          IllegalOp = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm. A trace model expands each instruction
// (opcode, stall counts, optional reset cut) into the per-cycle list of
// expected output vectors, which is then replayed against the DUT.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       MemReady = 1'b0;
  logic       IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc, IllegalOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;

  always #5 clk = ~clk;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp)
  );

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [6:0]  opv;
    logic [14:0] exp;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Observed outputs packed in the same order as the expected vectors
  wire [14:0] obs = {IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc,
                     ALUSrcA, ALUSrcB, ResultSrc, ALUOp, IllegalOp};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] v(input logic ir, input logic pc, input logic br,
                                    input logic rw, input logic mw, input logic adr,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] rs, input logic [1:0] ao,
                                    input logic ill);
    return {ir, pc, br, rw, mw, adr, sa, sb, rs, ao, ill};
  endfunction

  task automatic add(input logic rst, input logic rdy, input logic [6:0] o, input logic [14:0] e);
    ent_t x;
    x.rst = rst; x.rdy = rdy; x.opv = o; x.exp = e;
    q.push_back(x);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  // Expand one instruction into its expected cycle trace
  task automatic gen_instr(input logic [6:0] o, input int fs, input int ms);
    logic legal;
    for (int i = 0; i < fs; i++)
      add(1'b0, 1'b0, rnd_op(), v(0,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
    add(1'b0, 1'b1, rnd_op(), v(1,1,0,0,0,0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
    add(1'b0, rnd_bit(), o, v(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00, !legal));
    case (o)
      7'b0000011: begin
        add(1'b0, rnd_bit(), o, v(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        for (int i = 0; i < ms; i++)
          add(1'b0, 1'b0, o, v(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        add(1'b0, 1'b1, o, v(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        add(1'b0, rnd_bit(), o, v(0,0,0,1,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0));
      end
      7'b0100011: begin
        add(1'b0, rnd_bit(), o, v(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        for (int i = 0; i < ms; i++)
          add(1'b0, 1'b0, o, v(0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        add(1'b0, 1'b1, o, v(0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      end
      7'b0110011: begin
        add(1'b0, rnd_bit(), o, v(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 2'b10, 0));
        add(1'b0, rnd_bit(), o, v(0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      end
      7'b0010011: begin
        add(1'b0, rnd_bit(), o, v(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b10, 0));
        add(1'b0, rnd_bit(), o, v(0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      end
      7'b1101111: begin
        add(1'b0, rnd_bit(), o, v(0,1,0,0,0,0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        add(1'b0, rnd_bit(), o, v(0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      end
      7'b1100011: begin
        add(1'b0, rnd_bit(), o, v(0,0,1,0,0,0, 2'b10, 2'b00, 2'b00, 2'b01, 0));
      end
      default: begin
      end
    endcase
  endtask

  task automatic add_reset(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      add(1'b1, rdy, rnd_op(), 15'd0);
  endtask

  // Replay the queued trace: drive on the falling edge, sample 1ns later
  task automatic run_q();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      reset = e.rst;
      MemReady = e.rdy;
      op = e.opv;
      #1;
      check_eq($sformatf("cyc%0d_op%b_rst%0b", cyc, e.opv, e.rst), {17'd0, obs}, {17'd0, e.exp});
      cyc++;
    end
  endtask

  initial begin
    int base;
    int len;
    int kind;
    logic [6:0] o;
    logic [6:0] ops [6];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;

    // Reset held three cycles with MemReady high, then an unstalled beq
    add_reset(3, 1'b1);
    gen_instr(7'b1100011, 0, 0);
    // lw with a 2-cycle fetch stall, sw with a 3-cycle write stall
    gen_instr(7'b0000011, 2, 0);
    gen_instr(7'b0100011, 0, 3);
    // R, I, jal back to back, then an illegal opcode
    gen_instr(7'b0110011, 0, 0);
    gen_instr(7'b0010011, 0, 0);
    gen_instr(7'b1101111, 0, 0);
    gen_instr(7'b0000000, 0, 0);
    // Reset during a MEMWRITE stall: keep fetch+decode+memadr+2 stall cycles
    base = q.size();
    gen_instr(7'b0100011, 0, 5);
    while (q.size() > base + 5) void'(q.pop_back());
    add_reset(1, 1'b0);
    gen_instr(7'b0110011, 0, 0);
    run_q();

    // Random instruction stream with random stalls and occasional reset cuts
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 7);
      if (kind < 6) o = ops[kind];
      else o = rnd_op();
      base = q.size();
      gen_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        len = q.size() - base;
        len = $urandom_range(0, len - 1);
        while (q.size() > base + len) void'(q.pop_back());
        add_reset($urandom_range(1, 2), rnd_bit());
      end
      run_q();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
